// File: rtl/split_slave_responder.sv
// Bus slave with a DEPTH-word register file, programmable wait states and
// two-cycle ERROR/RETRY/SPLIT responses, plus a split-release pulse to the arbiter.
module split_slave_responder #(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned WAIT_STATES  = 1,
    parameter int unsigned SPLIT_BASE   = 48,
    parameter int unsigned SPLIT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        write,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [1:0]  resp,
    output logic        rdy,
    output logic        split
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(SPLIT_CYCLES + 1);

    localparam logic [16:0]   DEPTH_L  = 17'(DEPTH);
    localparam logic [16:0]   SBASE_L  = 17'(SPLIT_BASE);
    localparam logic [CW-1:0] CNT_LAST = CW'(SPLIT_CYCLES - 1);
    localparam logic [3:0]    WS_L     = 4'(WAIT_STATES);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_R1, S_R2} state_e;
    typedef enum logic [1:0] {T_FREE, T_BUSY, T_REL} trk_e;

    state_e          state_q;
    trk_e            trk_q;
    logic [15:0]     addr_q;
    logic [15:0]     lat_q;
    logic            write_q;
    logic [31:0]     wdata_q;
    logic [1:0]      code_q;
    logic [3:0]      wcnt_q;
    logic [CW-1:0]   cnt_q;
    logic            run_q;
    logic [31:0]     rdata_q;
    logic [1:0]      resp_q;
    logic            rdy_q;
    logic            split_q;
    logic [31:0]     mem_q [DEPTH];

    logic [1:0]      cls_d;
    logic [AW-1:0]   rd_idx_c;

    assign rdata = rdata_q;
    assign resp  = resp_q;
    assign rdy   = rdy_q;
    assign split = split_q;

    // With zero wait states the read happens on the accepting edge itself.
    assign rd_idx_c = (state_q == S_IDLE) ? addr[AW-1:0] : addr_q[AW-1:0];

    // Response class of a transfer presented this cycle; OKAY means NORMAL.
    always_comb begin
        cls_d = RESP_OKAY;
        if ({1'b0, addr} >= DEPTH_L) begin
            cls_d = RESP_ERROR;
        end else if (trk_q == T_BUSY) begin
            cls_d = RESP_RETRY;
        end else if ({1'b0, addr} >= SBASE_L) begin
            if (trk_q == T_FREE) begin
                cls_d = RESP_SPLIT;
            end else if (addr != lat_q) begin
                cls_d = RESP_RETRY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            trk_q   <= T_FREE;
            addr_q  <= '0;
            lat_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            code_q  <= RESP_OKAY;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
            rdy_q   <= 1'b1;
            split_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            split_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sel) begin
                        addr_q  <= addr;
                        write_q <= write;
                        wdata_q <= wdata;
                        code_q  <= cls_d;
                        if (cls_d == RESP_OKAY) begin
                            if (WS_L == 4'd0) begin
                                state_q <= S_DONE;
                                rdy_q   <= 1'b1;
                                if (!write) rdata_q <= mem_q[rd_idx_c];
                            end else begin
                                state_q <= S_WAIT;
                                wcnt_q  <= 4'd1;
                                rdy_q   <= 1'b0;
                            end
                        end else begin
                            state_q <= S_R1;
                            rdy_q   <= 1'b0;
                            resp_q  <= cls_d;
                        end
                        if (cls_d == RESP_SPLIT) begin
                            trk_q <= T_BUSY;
                            lat_q <= addr;
                            run_q <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == WS_L) begin
                        state_q <= S_DONE;
                        rdy_q   <= 1'b1;
                        if (!write_q) rdata_q <= mem_q[rd_idx_c];
                    end else begin
                        wcnt_q <= wcnt_q + 4'd1;
                    end
                end
                S_DONE: begin
                    if (write_q) mem_q[addr_q[AW-1:0]] <= wdata_q;
                    if (trk_q == T_REL && addr_q == lat_q) trk_q <= T_FREE;
                    state_q <= S_IDLE;
                end
                S_R1: begin
                    rdy_q   <= 1'b1;
                    state_q <= S_R2;
                    if (code_q == RESP_SPLIT) begin
                        cnt_q <= '0;
                        run_q <= 1'b1;
                    end
                end
                S_R2: begin
                    resp_q  <= RESP_OKAY;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // Release countdown; the counter freezes once the pulse has fired.
            if (trk_q == T_BUSY && run_q) begin
                if (cnt_q == CNT_LAST) begin
                    split_q <= 1'b1;
                    trk_q   <= T_REL;
                    run_q   <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

endmodule
